lvds_6x_serializer_tx: RTL and testbench

// - Transmit side of the 6x LVDS link, in the 300 MHz fast-clock domain.
// - Accepts parallel words per lane through a valid/ready handshake into a 2-entry buffer.
// - Shifts each word out MSB first, FACTOR bits per frame.
// - Generates the frame clock and a one-cycle load strobe that match the 1-in-6 load-enable timing.
// - Sends the training pattern whenever no data is available.
// - Drives the loopback test path and the link partner of the AFE deserializer.

---
 rtl/lvds_6x_serializer_tx.sv | 176 +++++++++++++++++
 tb/tb_lvds_6x_serializer_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_6x_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module   : lvds_6x_serializer_tx
// Purpose  : Transmit side of the 6x LVDS link. Buffers parallel lane words
//            in a 2-entry FIFO and shifts them out MSB first, FACTOR bits per
//            frame. Sends the training word when no data is buffered. Also
//            drives the frame clock, the load strobe, underrun and link status.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_6x_serializer_tx #(
    parameter int                FACTOR    = 6,
    parameter int                LANES     = 2,
    parameter logic [FACTOR-1:0] TRAIN_PAT = 6'b100111
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [LANES*FACTOR-1:0]   s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [LANES-1:0]          tx_lane,
    output logic                      tx_frame,
    output logic                      load_strobe,
    output logic                      underrun,
    output logic                      link_active
);

    localparam int               CNT_W  = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(FACTOR - 1);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(FACTOR / 2);
    localparam logic [1:0]       c_full = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CNT_W-1:0]          r_bit_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic                      w_boundary;
    logic                      w_underrun_next;

    logic [LANES*FACTOR-1:0]   r_mem [0:1];
    logic                      r_wr_ptr;
    logic                      r_rd_ptr;
    logic [1:0]                r_count;
    logic [1:0]                w_count_next;
    logic                      r_ready;
    logic                      w_push;
    logic                      w_pop;
    logic [LANES*FACTOR-1:0]   w_head;

    logic                      r_frame;
    logic                      r_load;
    logic                      r_underrun;
    logic                      r_link;

    assign w_boundary = (r_bit_cnt == c_last);
    assign w_cnt_next = w_boundary ? '0 : r_bit_cnt + 1'b1;
    assign w_push     = s_valid & r_ready;
    // The FIFO only drains when a data frame is about to start.
    assign w_pop      = w_boundary & (w_state_next == ST_DATA);
    assign w_head     = r_mem[r_rd_ptr];

    // Next state is decided only at the frame boundary; disable wins.
    always_comb begin
        w_state_next    = r_state;
        w_underrun_next = 1'b0;
        if (w_boundary) begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) w_state_next = ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (!enable)              w_state_next = ST_IDLE;
                    else if (r_count != 2'd0) w_state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (!enable) begin
                        w_state_next = ST_IDLE;
                    end else if (r_count == 2'd0) begin
                        w_state_next    = ST_TRAIN;
                        w_underrun_next = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Free-running bit counter and registered status outputs, all computed
    // from the next-cycle values so they line up with the serial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_load     <= 1'b0;
            r_frame    <= 1'b0;
            r_link     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bit_cnt  <= w_cnt_next;
            r_load     <= (w_cnt_next == c_last);
            r_frame    <= (w_cnt_next < c_half) && (w_state_next != ST_IDLE);
            r_link     <= (w_state_next != ST_IDLE);
            r_underrun <= w_underrun_next;
        end
    end

    // FIFO storage; contents are only meaningful under r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    // FIFO pointers, occupancy and registered ready (ready = not full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_full);
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [FACTOR-1:0] r_shift;

            // Whole-frame load at the boundary edge, left shift otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else if (w_boundary) begin
                    if (w_state_next == ST_DATA)       r_shift <= w_head[i*FACTOR +: FACTOR];
                    else if (w_state_next == ST_TRAIN) r_shift <= TRAIN_PAT;
                    else                               r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[FACTOR-2:0], 1'b0};
                end
            end

            assign tx_lane[i] = r_shift[FACTOR-1];
        end
    endgenerate

    assign s_ready     = r_ready;
    assign tx_frame    = r_frame;
    assign load_strobe = r_load;
    assign underrun    = r_underrun;
    assign link_active = r_link;

endmodule
`default_nettype wire

// File: tb/tb_lvds_6x_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_6x_serializer_tx
// Purpose  : Self-checking bench for lvds_6x_serializer_tx. Accepted words go
//            into a scoreboard queue; a frame monitor rebuilds each frame and
//            compares it with the queue head or the expected filler pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_6x_serializer_tx;

    localparam int          c_factor = 6;
    localparam int          c_lanes  = 2;
    localparam int          c_width  = c_factor * c_lanes;
    localparam logic [11:0] c_train  = 12'h9E7;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [c_width-1:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [c_lanes-1:0] tx_lane;
    logic               tx_frame;
    logic               load_strobe;
    logic               underrun;
    logic               link_active;

    logic               enable4;
    logic [3:0]         s_data4;
    logic               s_valid4;
    logic               s_ready4;
    logic [0:0]         tx_lane4;
    logic               tx_frame4;
    logic               load_strobe4;
    logic               underrun4;
    logic               link_active4;

    lvds_6x_serializer_tx u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .tx_lane(tx_lane),
        .tx_frame(tx_frame), .load_strobe(load_strobe), .underrun(underrun),
        .link_active(link_active)
    );

    lvds_6x_serializer_tx #(.FACTOR(4), .LANES(1), .TRAIN_PAT(4'b0101)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable4), .s_data(s_data4),
        .s_valid(s_valid4), .s_ready(s_ready4), .tx_lane(tx_lane4),
        .tx_frame(tx_frame4), .load_strobe(load_strobe4), .underrun(underrun4),
        .link_active(link_active4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [c_width-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int train_frames = 0, data_frames = 0, underruns = 0;
    int gaps = 0, train_after_data = 0, ready_low = 0;
    bit b2b = 0, b2b_seen = 0;

    // Frame monitor state
    logic [c_factor-1:0] shb [c_lanes];
    logic [c_factor-1:0] shf;
    logic [c_factor-1:0] exp_tf;
    logic [c_width-1:0]  fr;
    logic [c_width-1:0]  e;
    int  since_ls = 0;
    bit  have_ls  = 0;
    bit  last_data = 0;

    // Rebuild each frame from the serial outputs and score it at its last bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < c_lanes; i++) shb[i] = '0;
                shf = '0; since_ls = 0; have_ls = 0; last_data = 0;
            end else begin
                for (int i = 0; i < c_lanes; i++) shb[i] = {shb[i][c_factor-2:0], tx_lane[i]};
                shf = {shf[c_factor-2:0], tx_frame};
                since_ls++;
                if (underrun === 1'b1) underruns++;
                if (b2b && s_ready === 1'b0) ready_low++;
                if (load_strobe === 1'b1) begin
                    if (have_ls) begin
                        total++;
                        if (since_ls != c_factor) begin
                            bad++;
                            $display("FAIL strobe_period got=%0d want=%0d", since_ls, c_factor);
                        end
                    end
                    have_ls = 1; since_ls = 0;
                    for (int i = 0; i < c_lanes; i++) fr[i*c_factor +: c_factor] = shb[i];
                    exp_tf = (link_active === 1'b1) ? 6'b111000 : 6'b000000;
                    total++;
                    if (shf !== exp_tf) begin
                        bad++;
                        $display("FAIL frame_clock got=%b want=%b", shf, exp_tf);
                    end
                    if (link_active !== 1'b1) begin
                        total++;
                        if (fr !== '0) begin
                            bad++;
                            $display("FAIL idle_frame got=%h want=000", fr);
                        end
                        last_data = 0;
                    end else if (fr === c_train) begin
                        train_frames++;
                        if (last_data) train_after_data++;
                        if (b2b && b2b_seen && exp_q.size() > 0) gaps++;
                        last_data = 0;
                    end else begin
                        data_frames++;
                        last_data = 1;
                        if (b2b) b2b_seen = 1;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_data got=%h want=none", fr);
                        end else begin
                            e = exp_q.pop_front();
                            if (fr !== e) begin
                                bad++;
                                $display("FAIL data_frame got=%h want=%h", fr, e);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [c_width-1:0] w);
        int t = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept ready=%b want=1 word=%h", s_ready, w);
        end else begin
            @(posedge clk);
            exp_q.push_back(w);
            #1;
        end
    endtask

    task automatic wait_qsize(input int n, input int limit, output bit ok);
        ok = 0;
        for (int t = 0; t < limit; t++) begin
            @(posedge clk);
            if (exp_q.size() == n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_link(input logic want, input int limit, output bit ok);
        ok = 0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (link_active === want) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_lane !== 2'b00)    begin bad++; $display("FAIL rst_tx_lane got=%b want=00", tx_lane); end
        total++; if (tx_frame !== 1'b0)    begin bad++; $display("FAIL rst_tx_frame got=%b want=0", tx_frame); end
        total++; if (load_strobe !== 1'b0) begin bad++; $display("FAIL rst_load_strobe got=%b want=0", load_strobe); end
        total++; if (underrun !== 1'b0)    begin bad++; $display("FAIL rst_underrun got=%b want=0", underrun); end
        total++; if (link_active !== 1'b0) begin bad++; $display("FAIL rst_link got=%b want=0", link_active); end
        total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL rst_ready got=%b want=0", s_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_ready !== 1'b1)     begin bad++; $display("FAIL ready_after_rst got=%b want=1", s_ready); end
        repeat (8) @(negedge clk);
        total++; if (link_active !== 1'b0) begin bad++; $display("FAIL idle_link got=%b want=0", link_active); end
    endtask

    task automatic test_train;
        bit ok;
        int u0 = underruns;
        int t0 = train_frames;
        enable = 1'b1;
        wait_link(1'b1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL train_link got=%b want=1", link_active); end
        repeat (4 * c_factor) @(posedge clk);
        total++; if (train_frames - t0 < 3) begin bad++; $display("FAIL train_frames got=%0d want>=3", train_frames - t0); end
        total++; if (underruns != u0) begin bad++; $display("FAIL train_underrun got=%0d want=0", underruns - u0); end
    endtask

    task automatic test_single_word;
        bit ok;
        int u0   = underruns;
        int tad0 = train_after_data;
        int d0   = data_frames;
        @(negedge clk);
        send(12'hA5C);
        s_valid = 1'b0;
        wait_qsize(0, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_drain got=%0d want=0", exp_q.size()); end
        repeat (2 * c_factor) @(posedge clk);
        total++; if (data_frames - d0 != 1)        begin bad++; $display("FAIL single_count got=%0d want=1", data_frames - d0); end
        total++; if (underruns - u0 != 1)          begin bad++; $display("FAIL single_underrun got=%0d want=1", underruns - u0); end
        total++; if (train_after_data - tad0 != 1) begin bad++; $display("FAIL single_train_after got=%0d want=1", train_after_data - tad0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int u0 = underruns;
        int d0 = data_frames;
        b2b = 1; b2b_seen = 0; gaps = 0; ready_low = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(12'h101 + 12'(i) * 12'h111);
        s_valid = 1'b0;
        wait_qsize(0, 150, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_drain got=%0d want=0", exp_q.size()); end
        repeat (2 * c_factor) @(posedge clk);
        b2b = 0;
        total++; if (gaps != 0)             begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
        total++; if (ready_low == 0)        begin bad++; $display("FAIL b2b_backpressure got=%0d want>0", ready_low); end
        total++; if (data_frames - d0 != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", data_frames - d0); end
        total++; if (underruns - u0 != 1)   begin bad++; $display("FAIL b2b_underrun got=%0d want=1", underruns - u0); end
    endtask

    task automatic test_disable;
        bit ok;
        int t0;
        @(negedge clk);
        send(12'h1A2); send(12'h2B3); send(12'h3C4);
        s_valid = 1'b0;
        wait_qsize(2, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL dis_first got=%0d want=2", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        wait_link(1'b0, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL dis_link got=%b want=0", link_active); end
        @(negedge clk);
        total++; if (tx_lane !== 2'b00) begin bad++; $display("FAIL dis_tx_lane got=%b want=00", tx_lane); end
        total++; if (tx_frame !== 1'b0) begin bad++; $display("FAIL dis_tx_frame got=%b want=0", tx_frame); end
        repeat (2 * c_factor) @(posedge clk);
        total++; if (exp_q.size() != 1) begin bad++; $display("FAIL dis_retained got=%0d want=1", exp_q.size()); end
        t0 = train_frames;
        @(negedge clk);
        enable = 1'b1;
        wait_qsize(0, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL reen_drain got=%0d want=0", exp_q.size()); end
        total++; if (train_frames - t0 != 1) begin bad++; $display("FAIL reen_train got=%0d want=1", train_frames - t0); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        @(negedge clk);
        send(12'h4D5); send(12'h5E6); send(12'h6F7);
        s_valid = 1'b0;
        wait_qsize(2, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_first got=%0d want=2", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (tx_lane !== 2'b00)    begin bad++; $display("FAIL rm_tx_lane got=%b want=00", tx_lane); end
        total++; if (tx_frame !== 1'b0)    begin bad++; $display("FAIL rm_tx_frame got=%b want=0", tx_frame); end
        total++; if (load_strobe !== 1'b0) begin bad++; $display("FAIL rm_strobe got=%b want=0", load_strobe); end
        total++; if (link_active !== 1'b0) begin bad++; $display("FAIL rm_link got=%b want=0", link_active); end
        total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL rm_ready got=%b want=0", s_ready); end
        exp_q.delete();
        d0 = data_frames;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_rel got=%b want=1", s_ready); end
        repeat (5 * c_factor) @(posedge clk);
        total++; if (data_frames != d0)    begin bad++; $display("FAIL rm_stale got=%0d want=0", data_frames - d0); end
        total++; if (link_active !== 1'b1) begin bad++; $display("FAIL rm_relink got=%b want=1", link_active); end
    endtask

    task automatic test_factor4;
        bit ok;
        bit found = 0;
        int lsc;
        logic [3:0] bits = '0;
        logic [3:0] tfb  = '0;
        @(negedge clk);
        enable4 = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (link_active4 === 1'b1) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL f4_link got=%b want=1", link_active4); end
        total++; if (s_ready4 !== 1'b1) begin bad++; $display("FAIL f4_ready got=%b want=1", s_ready4); end
        s_data4  = 4'b1001;
        s_valid4 = 1'b1;
        @(posedge clk);
        #1 s_valid4 = 1'b0;
        ok = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (load_strobe4 === 1'b1) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL f4_align got=%b want=1", load_strobe4); end
        for (int f = 0; f < 4; f++) begin
            lsc = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bits = {bits[2:0], tx_lane4[0]};
                tfb  = {tfb[2:0], tx_frame4};
                if (load_strobe4 === 1'b1) lsc++;
            end
            total++; if (lsc != 1 || load_strobe4 !== 1'b1) begin bad++; $display("FAIL f4_strobe got=%0d/%b want=1/1", lsc, load_strobe4); end
            total++; if (tfb !== 4'b1100) begin bad++; $display("FAIL f4_frame got=%b want=1100", tfb); end
            if (bits === 4'b1001) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL f4_word got=%b want=1001", bits); end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        enable4 = 1'b0; s_valid4 = 1'b0; s_data4 = '0;
        test_reset();
        test_train();
        test_single_word();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        test_factor4();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
